// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - shared widths, FSM encodings and reset constants for the instruction queue
package instr_queue_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } iq_state_t;

  localparam logic [15:0] RST_CS_DEFAULT = 16'hFFFF;
  localparam logic [15:0] RST_IP_DEFAULT = 16'h0000;

  // Segmented address: cs*16 + ip, truncated to the 20-bit physical space.
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
    return {cs, 4'b0000} + {4'b0000, ip};
  endfunction

endpackage

// File: rtl/iq_fifo.sv
// rtl/iq_fifo.sv - byte FIFO with 0/1/2-byte push and 1-byte pop
module iq_fifo #(
  parameter int DEPTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [1:0]                 push_n,
  input  logic [7:0]                 push_b0,
  input  logic [7:0]                 push_b1,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] free
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr_p1, wptr_p2;
  logic [CW-1:0] count;
  logic          pop_ok;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign wptr_p1 = wrap_inc(wptr);
  assign wptr_p2 = wrap_inc(wptr_p1);
  assign pop_ok  = pop && (count != '0);
  assign valid   = (count != '0);
  assign head    = valid ? mem[rptr] : 8'h00;
  assign free    = CW'(DEPTH) - count;

  // Byte storage: first byte at the write pointer, second byte one slot after.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_n != 2'd0) mem[wptr]    <= push_b0;
      if (push_n == 2'd2) mem[wptr_p1] <= push_b1;
    end
  end

  // Pointers and occupancy; clear returns everything to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      case (push_n)
        2'd1:    wptr <= wptr_p1;
        2'd2:    wptr <= wptr_p2;
        default: wptr <= wptr;
      endcase
      if (pop_ok) rptr <= wrap_inc(rptr);
      count <= count + CW'(push_n) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - instruction prefetch queue: fetch FSM, address generation and byte queue
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int          DEPTH  = 6,
  parameter logic [15:0] RST_CS = RST_CS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              req,
  input  logic              ack,
  output logic              rw,
  output logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] dtw,
  input  logic [DATA_W-1:0] dtr,
  output logic [7:0]        q_byte,
  output logic              q_valid,
  input  logic              q_pop,
  output logic [15:0]       q_ip,
  input  logic              flush,
  input  logic [15:0]       flush_cs,
  input  logic [15:0]       flush_ip
);

  localparam int CW = $clog2(DEPTH+1);

  iq_state_t         state, state_nx;
  logic [15:0]       cs, fetch_ip;
  logic              fetch_odd;
  logic [CW-1:0]     free;
  logic              start, take, pop_ok;
  logic [1:0]        push_n;
  logic [7:0]        push_b0;
  logic [ADDR_W-1:0] pa;

  assign pa      = phys_addr(cs, fetch_ip);
  assign start   = (state == ST_IDLE) && !flush && (free >= CW'(2));
  assign take    = (state == ST_REQ) && ack && !flush;
  assign pop_ok  = q_pop && q_valid && !flush;
  assign push_n  = take ? (fetch_odd ? 2'd1 : 2'd2) : 2'd0;
  assign push_b0 = fetch_odd ? dtr[15:8] : dtr[7:0];
  assign req     = (state != ST_IDLE);
  assign rw      = 1'b1;
  assign dtw     = '0;

  iq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .push_n  (push_n),
    .push_b0 (push_b0),
    .push_b1 (dtr[15:8]),
    .pop     (pop_ok),
    .head    (q_byte),
    .valid   (q_valid),
    .free    (free)
  );

  // Fetch FSM next state: a flush during an open request turns it into a discard.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start) state_nx = ST_REQ;
      ST_REQ:     if (ack) state_nx = ST_IDLE;
                  else if (flush) state_nx = ST_DISCARD;
      ST_DISCARD: if (ack) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Segment/IP tracking; adr is captured at request start so it holds through any flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs        <= RST_CS;
      fetch_ip  <= RST_IP_DEFAULT;
      q_ip      <= RST_IP_DEFAULT;
      adr       <= '0;
      fetch_odd <= 1'b0;
    end else begin
      if (flush) begin
        cs       <= flush_cs;
        fetch_ip <= flush_ip;
        q_ip     <= flush_ip;
      end else begin
        if (take)   fetch_ip <= fetch_ip + (fetch_odd ? 16'd1 : 16'd2);
        if (pop_ok) q_ip     <= q_ip + 16'd1;
      end
      if (start) begin
        adr       <= pa & {{(ADDR_W-1){1'b1}}, 1'b0};
        fetch_odd <= fetch_ip[0];
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - self-checking bench for instr_queue against a transaction-level model
module tb_instr_queue;

  localparam int DEPTH = 6;

  logic        clk;
  logic        rst_n;
  logic        req, ack, rw;
  logic [19:0] adr;
  logic [15:0] dtw, dtr;
  logic [7:0]  q_byte;
  logic        q_valid, q_pop;
  logic [15:0] q_ip;
  logic        flush;
  logic [15:0] flush_cs, flush_ip;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  instr_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .rw       (rw),
    .adr      (adr),
    .dtw      (dtw),
    .dtr      (dtr),
    .q_byte   (q_byte),
    .q_valid  (q_valid),
    .q_pop    (q_pop),
    .q_ip     (q_ip),
    .flush    (flush),
    .flush_cs (flush_cs),
    .flush_ip (flush_ip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: byte queue, segment/IP registers, one outstanding read.
  logic [7:0]  mq[$];
  logic [15:0] m_cs = 16'hFFFF, m_ip = 16'h0, m_qip = 16'h0;
  bit          m_out = 0, m_disc = 0, m_odd = 0;
  logic [19:0] m_adr = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_cs = 16'hFFFF; m_ip = 16'h0; m_qip = 16'h0;
        m_out = 0; m_disc = 0; m_odd = 0;
      end else begin
        int  sz;
        bit  st;
        logic [19:0] p;
        sz = mq.size();
        st = !m_out && !flush && (DEPTH - sz >= 2);
        if (m_out && ack) begin
          if (!m_disc && !flush) begin
            if (m_odd) begin
              mq.push_back(dtr[15:8]);
              m_ip = m_ip + 16'd1;
            end else begin
              mq.push_back(dtr[7:0]);
              mq.push_back(dtr[15:8]);
              m_ip = m_ip + 16'd2;
            end
          end
          m_out = 0;
          m_disc = 0;
        end else if (m_out && flush) begin
          m_disc = 1;
        end
        if (q_pop && sz > 0 && !flush) begin
          void'(mq.pop_front());
          m_qip = m_qip + 16'd1;
        end
        if (flush) begin
          mq.delete();
          m_cs = flush_cs; m_ip = flush_ip; m_qip = flush_ip;
        end
        if (st) begin
          p = {m_cs, 4'b0000} + {4'b0000, m_ip};
          m_adr = {p[19:1], 1'b0};
          m_odd = m_ip[0];
          m_out = 1;
          m_disc = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, just after each rising edge settles.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cmp_en) begin
        chk("req", 32'(req), 32'(m_out));
        if (m_out) chk("adr", 32'(adr), 32'(m_adr));
        chk("q_valid", 32'(q_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("q_byte", 32'(q_byte), 32'(mq[0]));
        if (!rst_n) chk("q_byte_rst", 32'(q_byte), 32'h0);
        chk("q_ip", 32'(q_ip), 32'(m_qip));
        chk("rw", 32'(rw), 32'h1);
        chk("dtw", 32'(dtw), 32'h0);
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req) chk("req_timeout", 32'(req), 32'h1);
  endtask

  task automatic do_ack(input logic [15:0] d);
    ack = 1'b1;
    dtr = d;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic do_flush(input logic [15:0] c, input logic [15:0] i);
    flush = 1'b1;
    flush_cs = c;
    flush_ip = i;
    @(negedge clk);
    flush = 1'b0;
  endtask

  logic [19:0] exp_adr [3];

  initial begin
    exp_adr[0] = 20'hFFFF0;
    exp_adr[1] = 20'hFFFF2;
    exp_adr[2] = 20'hFFFF4;
    rst_n = 1'b0; ack = 1'b0; dtr = '0; q_pop = 1'b0;
    flush = 1'b0; flush_cs = '0; flush_ip = '0;
    @(posedge clk);
    cmp_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_q_valid", 32'(q_valid), 32'h0);
    chk("rst_q_byte", 32'(q_byte), 32'h0);
    chk("rst_rw", 32'(rw), 32'h1);
    chk("rst_dtw", 32'(dtw), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(req), 32'h1);
    chk("first_adr", 32'(adr), 32'hFFFF0);

    // Fill the queue with three even fetches.
    for (int k = 0; k < 3; k++) begin
      wait_req();
      chk("fill_adr", 32'(adr), 32'(exp_adr[k]));
      do_ack(16'hA55A);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("full_req_low", 32'(req), 32'h0);
    chk("full_head", 32'(q_byte), 32'h5A);

    // Two pops free one word and re-trigger the fetch.
    chk("pop0_ip", 32'(q_ip), 32'h0);
    q_pop = 1'b1;
    @(negedge clk);
    chk("pop1_byte", 32'(q_byte), 32'hA5);
    chk("pop1_ip", 32'(q_ip), 32'h1);
    @(negedge clk);
    q_pop = 1'b0;
    chk("pop2_ip", 32'(q_ip), 32'h2);
    wait_req();
    chk("refill_adr", 32'(adr), 32'hFFFF6);
    do_ack(16'hA55A);

    // Flush to an odd IP: only the high byte is queued.
    do_flush(16'h1000, 16'h0003);
    wait_req();
    chk("odd_adr", 32'(adr), 32'h10002);
    do_ack(16'hBEEF);
    chk("odd_valid", 32'(q_valid), 32'h1);
    chk("odd_byte", 32'(q_byte), 32'hBE);
    chk("odd_qip", 32'(q_ip), 32'h3);
    wait_req();
    chk("odd_next_adr", 32'(adr), 32'h10004);

    // Flush with a request outstanding: old adr held, returned data dropped.
    do_flush(16'h2000, 16'h0100);
    chk("disc_req", 32'(req), 32'h1);
    chk("disc_adr", 32'(adr), 32'h10004);
    @(negedge clk);
    chk("disc_adr2", 32'(adr), 32'h10004);
    do_ack(16'h1234);
    chk("disc_empty", 32'(q_valid), 32'h0);
    wait_req();
    chk("disc_new_adr", 32'(adr), 32'h20100);
    do_ack(16'h5678);
    chk("disc_new_byte", 32'(q_byte), 32'h78);

    // IP wraps inside the segment.
    do_flush(16'h0000, 16'hFFFE);
    wait_req();
    chk("wrap_adr0", 32'(adr), 32'h0FFFE);
    do_ack(16'h0102);
    wait_req();
    chk("wrap_adr1", 32'(adr), 32'h00000);

    // Asynchronous reset mid-request, with a stray ack around the release.
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(req), 32'h0);
    chk("async_q_valid", 32'(q_valid), 32'h0);
    @(negedge clk);
    ack = 1'b1;
    dtr = 16'hDEAD;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", 32'(req), 32'h1);
    chk("restart_adr", 32'(adr), 32'hFFFF0);
    chk("stray_no_push", 32'(q_valid), 32'h0);
    ack = 1'b0;

    // Randomized traffic, checked every cycle by the model comparison.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ack   = req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      dtr   = 16'($urandom);
      q_pop = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 39) == 0);
      flush_cs = 16'($urandom);
      flush_ip = 16'($urandom);
    end
    @(negedge clk);
    ack = 1'b0; q_pop = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 6, meaning queue capacity in bytes (even, 4..16).
REQ-002 The block SHALL have parameter RST_CS, default 16'hFFFF, meaning the code segment value loaded at reset.
REQ-003 The block SHALL have these ports:
 - clk  in  1  single clock; all state updates on the rising edge.
 - rst_n  in  1  asynchronous, active-low reset.
 - req  out  1  bus request to the IO arbiter, port 0.
 - ack  in  1  one-cycle grant; dtr is valid in the same cycle.
 - rw  out  1  access direction; tied to 1 (read).
 - adr  out  20  physical word address; bit 0 always 0.
 - dtw  out  16  write data; tied to 0.
 - dtr  in  16  read data; low byte = even address.
 - q_byte  out  8  head byte for the decoder.
 - q_valid  out  1  head byte valid.
 - q_pop  in  1  decoder consumes the head byte; ignored when q_valid=0.
 - q_ip  out  16  IP of the head byte.
 - flush  in  1  redirect fetch; discard the queue.
 - flush_cs  in  16  new CS, sampled when flush=1.
 - flush_ip  in  16  new IP, sampled when flush=1.

Function
REQ-004 Physical address SHALL be ({cs,4'b0} + {4'b0,fetch_ip}) mod 2^20; adr SHALL be that value with bit 0 cleared.
REQ-005 Fetch IP SHALL advance modulo 2^16: +1 after an odd-IP fetch, otherwise +2. CS SHALL NOT change on wrap.
REQ-006 req SHALL assert when no request is outstanding, flush=0, and free space is at least 2 bytes.
REQ-007 Once asserted, req, adr and rw SHALL hold stable until the cycle ack=1. req SHALL deassert on the clock edge that samples ack, giving a minimum of one idle cycle between requests.
REQ-008 On ack with an even fetch IP, the block SHALL push two bytes: dtr[7:0] then dtr[15:8].
REQ-009 On ack with an odd fetch IP, the block SHALL push dtr[15:8] only.
REQ-010 Pushed bytes SHALL appear at the head no earlier than the cycle after ack, giving fetch-to-q_valid latency of 1 cycle on an empty queue.
REQ-011 Push and pop in the same cycle SHALL both take effect. Count SHALL equal count + pushed − popped. The queue SHALL never overflow (guaranteed by REQ-006).
REQ-012 q_ip SHALL increment mod 2^16 on each accepted pop.
REQ-013 Write and read pointers SHALL wrap modulo DEPTH.
REQ-014 flush (single cycle) SHALL, on that edge:
 - empty the queue (q_valid=0 next cycle);
 - load cs=flush_cs, fetch_ip=flush_ip, q_ip=flush_ip;
 - ignore any q_pop in that cycle.
REQ-015 If flush occurs while a request is outstanding:
 - req SHALL stay asserted with the old adr until ack;
 - the returned data SHALL be discarded;
 - the new fetch SHALL start the cycle after that ack.
REQ-016 If flush and ack coincide, the ack data SHALL be discarded and the outstanding state cleared.
REQ-017 A second flush before a pending discard completes SHALL overwrite cs/ip without adding further discards.
REQ-018 Control SHALL be a 3-state FSM:
 - IDLE -> REQ when REQ-006 holds;
 - REQ -> IDLE on ack;
 - REQ -> DISCARD on flush without ack;
 - DISCARD -> IDLE on ack.

Reset
REQ-019 While rst_n=0, outputs SHALL be: req=0, rw=1, dtw=0, q_valid=0, q_byte=0.
REQ-020 While rst_n=0, state SHALL be: state=IDLE, count=0, pointers=0, cs=RST_CS, fetch_ip=0, q_ip=0.
REQ-021 If reset asserts mid-request, req SHALL drop immediately, the transaction SHALL be abandoned, and no data SHALL be pushed.
REQ-022 The first req SHALL assert on the first rising edge after rst_n deasserts, with adr=20'hFFFF0 at default parameters.

Structure
REQ-023 A shared package SHALL hold:
 - address width 20 and data width 16;
 - the FSM state encodings;
 - default reset CS/IP constants (shared with the execution engine).
REQ-024 Byte storage, pointers and count SHALL live in sub-module iq_fifo. iq_fifo SHALL provide a 0/1/2-byte push port and a 1-byte pop port. instr_queue SHALL hold the FSM and address logic.

Verification
REQ-025 Reset then ack every 3rd cycle with dtr=16'hA55A, no pops -> adr=20'hFFFF0, then 20'hFFFF2, then 20'hFFFF4; count reaches 6; req stays low once full.
REQ-026 Full queue, q_pop held 1 for 2 cycles -> q_byte sequence 8'h5A, 8'hA5; q_ip 0 -> 2; req reasserts with adr=20'hFFFF6.
REQ-027 flush with cs=16'h1000, ip=16'h0003 on an empty queue, ack dtr=16'hBEEF -> adr=20'h10002; only 8'hBE is queued; q_ip=3; next adr=20'h10004.
REQ-028 flush while req is outstanding, ack 2 cycles later with dtr=16'h1234 -> old adr held until ack; 8'h34/8'h12 never appear; new adr issued the next cycle.
REQ-029 fetch_ip=16'hFFFE with cs=16'h0000 -> adr=20'h0FFFE, then adr=20'h00000 (IP wraps within segment).
REQ-030 rst_n pulsed low while req=1 -> req=0 and q_valid=0 asynchronously; no push on a stray ack; restart at adr=20'hFFFF0.
